// File: rtl/pingpong_buffer_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pingpong_buffer_ctrl
// Brief    : Two-bank ping-pong frame buffer. A producer fills one bank of
//            DEPTH words while a consumer drains the other; banks swap on
//            completed frames so both sides never touch the same bank.
// Ports    : clk, rst            - clock, synchronous active-high reset
//            wr_valid/wr_data/wr_ready - producer handshake
//            rd_valid/rd_data/rd_ready - consumer handshake
//            flush               - drop the partially filled frame
//            bank_full[1:0]      - per-bank full flags (bit b = bank b)
//            wr_bank / rd_bank   - bank being filled / drained
//            frame_done          - one-cycle pulse after a bank is drained
// Revision : 1.0 - initial release
// ============================================================================
module pingpong_buffer_ctrl #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_valid,
    input  logic [WIDTH-1:0] wr_data,
    output logic             wr_ready,
    output logic             rd_valid,
    output logic [WIDTH-1:0] rd_data,
    input  logic             rd_ready,
    input  logic             flush,
    output logic [1:0]       bank_full,
    output logic             wr_bank,
    output logic             rd_bank,
    output logic             frame_done
);

    localparam int               CNT_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] c_LAST_IDX = CNT_W'(DEPTH - 1);

    // Bank storage; contents are intentionally left unreset.
    logic [WIDTH-1:0] r_mem [0:1][0:DEPTH-1];

    logic [CNT_W-1:0] r_wr_cnt;
    logic [CNT_W-1:0] r_rd_cnt;
    logic             r_wr_bank;
    logic             r_rd_bank;
    logic [1:0]       r_bank_full;
    logic             r_frame_done;

    logic             w_wr_ready;
    logic             w_rd_valid;
    logic             w_wr_fire;
    logic             w_rd_fire;
    logic             w_wr_last;
    logic             w_rd_last;
    logic [1:0]       w_full_nxt;

    assign w_wr_ready = ~r_bank_full[r_wr_bank];
    assign w_rd_valid = r_bank_full[r_rd_bank];

    // flush wins over a same-cycle write.
    assign w_wr_fire  = wr_valid & w_wr_ready & ~flush;
    assign w_rd_fire  = w_rd_valid & rd_ready;
    assign w_wr_last  = w_wr_fire & (r_wr_cnt == c_LAST_IDX);
    assign w_rd_last  = w_rd_fire & (r_rd_cnt == c_LAST_IDX);

    // Write-side completion and read-side completion always hit different
    // banks, so both updates can be merged without priority.
    always_comb begin
        w_full_nxt = r_bank_full;
        if (w_wr_last) begin
            w_full_nxt[r_wr_bank] = 1'b1;
        end
        if (w_rd_last) begin
            w_full_nxt[r_rd_bank] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_wr_fire) begin
            r_mem[r_wr_bank][r_wr_cnt] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_cnt     <= '0;
            r_rd_cnt     <= '0;
            r_wr_bank    <= 1'b0;
            r_rd_bank    <= 1'b0;
            r_bank_full  <= 2'b00;
            r_frame_done <= 1'b0;
        end else begin
            r_bank_full  <= w_full_nxt;
            r_frame_done <= w_rd_last;

            if (flush) begin
                r_wr_cnt <= '0;
            end else if (w_wr_last) begin
                r_wr_cnt  <= '0;
                r_wr_bank <= ~r_wr_bank;
            end else if (w_wr_fire) begin
                r_wr_cnt <= r_wr_cnt + 1'b1;
            end

            if (w_rd_last) begin
                r_rd_cnt  <= '0;
                r_rd_bank <= ~r_rd_bank;
            end else if (w_rd_fire) begin
                r_rd_cnt <= r_rd_cnt + 1'b1;
            end
        end
    end

    assign wr_ready   = w_wr_ready;
    assign rd_valid   = w_rd_valid;
    assign rd_data    = r_mem[r_rd_bank][r_rd_cnt];
    assign bank_full  = r_bank_full;
    assign wr_bank    = r_wr_bank;
    assign rd_bank    = r_rd_bank;
    assign frame_done = r_frame_done;

    // Filling and draining the same bank in one cycle would corrupt a frame.
    a_no_same_bank : assert property (@(posedge clk) disable iff (rst)
        !(w_wr_fire && w_rd_fire && (r_wr_bank == r_rd_bank)));

endmodule
`default_nettype wire

// File: tb/tb_pingpong_buffer_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pingpong_buffer_ctrl
// Brief    : Self-checking bench for pingpong_buffer_ctrl. A frame-level
//            model (queues of words, frame counters) predicts every output.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pingpong_buffer_ctrl;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    logic             clk;
    logic             rst;
    logic             wr_valid;
    logic [WIDTH-1:0] wr_data;
    logic             wr_ready;
    logic             rd_valid;
    logic [WIDTH-1:0] rd_data;
    logic             rd_ready;
    logic             flush;
    logic [1:0]       bank_full;
    logic             wr_bank;
    logic             rd_bank;
    logic             frame_done;

    pingpong_buffer_ctrl #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .wr_valid   (wr_valid),
        .wr_data    (wr_data),
        .wr_ready   (wr_ready),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data),
        .rd_ready   (rd_ready),
        .flush      (flush),
        .bank_full  (bank_full),
        .wr_bank    (wr_bank),
        .rd_bank    (rd_bank),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: words of complete frames waiting to be read, the
    // partially written frame, and frame counters since the last reset.
    logic [WIDTH-1:0] m_full_q [$];
    logic [WIDTH-1:0] m_part_q [$];
    int               m_nfull;
    int               m_written;
    int               m_drained;
    int               m_rd_idx;
    bit               m_fd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: observed 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_full_q.delete();
        m_part_q.delete();
        m_nfull   = 0;
        m_written = 0;
        m_drained = 0;
        m_rd_idx  = 0;
        m_fd      = 1'b0;
    endtask

    function automatic logic [1:0] exp_full();
        logic [1:0] f;
        f = 2'b00;
        if (m_nfull == 2) f = 2'b11;
        else if (m_nfull == 1) f[m_drained % 2] = 1'b1;
        return f;
    endfunction

    // One clock cycle: drive inputs, check outputs mid-cycle, advance model.
    task automatic step(input logic i_rst, input logic wv, input logic [WIDTH-1:0] wd,
                        input logic rr, input logic fl);
        bit e_wr_ready, e_rd_valid, wfire, rfire, fd_n;
        rst      = i_rst;
        wr_valid = wv;
        wr_data  = wd;
        rd_ready = rr;
        flush    = fl;
        e_wr_ready = (m_nfull < 2);
        e_rd_valid = (m_nfull > 0);
        @(negedge clk);
        chk("wr_ready",   32'(wr_ready),   32'(e_wr_ready));
        chk("rd_valid",   32'(rd_valid),   32'(e_rd_valid));
        if (e_rd_valid) chk("rd_data", 32'(rd_data), 32'(m_full_q[0]));
        chk("bank_full",  32'(bank_full),  32'(exp_full()));
        chk("wr_bank",    32'(wr_bank),    32'(m_written % 2));
        chk("rd_bank",    32'(rd_bank),    32'(m_drained % 2));
        chk("frame_done", 32'(frame_done), 32'(m_fd));
        wfire = wv && e_wr_ready && !fl;
        rfire = rr && e_rd_valid;
        @(posedge clk);
        #1;
        if (i_rst) begin
            model_reset();
        end else begin
            fd_n = 1'b0;
            if (rfire) begin
                void'(m_full_q.pop_front());
                m_rd_idx++;
                if (m_rd_idx == DEPTH) begin
                    m_rd_idx = 0;
                    m_nfull--;
                    m_drained++;
                    fd_n = 1'b1;
                end
            end
            if (fl) begin
                m_part_q.delete();
            end else if (wfire) begin
                m_part_q.push_back(wd);
                if (m_part_q.size() == DEPTH) begin
                    foreach (m_part_q[k]) m_full_q.push_back(m_part_q[k]);
                    m_part_q.delete();
                    m_nfull++;
                    m_written++;
                end
            end
            m_fd = fd_n;
        end
    endtask

    initial begin
        rst      = 1'b1;
        wr_valid = 1'b0;
        wr_data  = '0;
        rd_ready = 1'b0;
        flush    = 1'b0;
        @(posedge clk);
        #1;
        model_reset();

        // Reset state, then one frame 0x11..0x14 with the consumer idle.
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 8'(8'h11 + i), 1'b0, 1'b0);
        // Second frame, then a write attempt against two full banks.
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 8'(8'h21 + i), 1'b0, 1'b0);
        step(1'b0, 1'b1, 8'h99, 1'b0, 1'b0);
        // Drain both frames.
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        // Streaming 16 words.
        for (int i = 0; i < 20; i++) step(1'b0, (i < 16), 8'(8'h40 + i), 1'b1, 1'b0);
        // Partial frame discarded by flush (with a concurrent write).
        step(1'b0, 1'b1, 8'hA1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 8'hA2, 1'b0, 1'b0);
        step(1'b0, 1'b1, 8'hA3, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 8'(8'h31 + i), 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        // Reset in the middle of a drain.
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 8'(8'h51 + i), 1'b0, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b1, 1'b1, 8'h77, 1'b1, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        // Randomized traffic with occasional flush and reset.
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 79) == 0),
                 ($urandom_range(0, 3) != 0),
                 8'($urandom),
                 ($urandom_range(0, 2) != 0),
                 ($urandom_range(0, 19) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
